// File: rtl/warmboot_pkg.sv
// Shared types and constants for the warm-boot control stage.
package warmboot_pkg;
  typedef enum logic [2:0] {IDLE, HELD, CONFIRM, ARM, BOOT} state_t;
  typedef logic [1:0] image_t;
  localparam int NUM_IMAGES = 4;
endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer: active-low raw input in, debounced
// pressed level and a one-cycle press pulse out.
module btn_debounce #(
  parameter int LOG2DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press
);
  logic sync0_n, sync1_n, db_n;
  logic [LOG2DEBOUNCE-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_n <= 1'b1;
      sync1_n <= 1'b1;
      db_n    <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync0_n <= btn_n;
      sync1_n <= sync0_n;
      press   <= 1'b0;
      // any cycle agreeing with the current level restarts the window
      if (sync1_n != db_n) begin
        if (cnt == '1) begin
          db_n  <= sync1_n;
          cnt   <= '0;
          press <= ~sync1_n;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pressed = ~db_n;
endmodule

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer in front of SB_WARMBOOT. Optional confirm step for
// long presses is enabled with `define WARMBOOT_CONFIRM_EN.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int LOG2DEBOUNCE      = 16,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int SETUP_CYCLES      = 4,
  parameter int LOG2CONFIRM       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       req,
  input  logic [1:0] req_image,
  output logic       boot,
  output logic       s1,
  output logic       s0,
  output logic [1:0] image_sel,
  output logic       busy
);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int SW = $clog2(SETUP_CYCLES + 1);

  if (LONG_PRESS_CYCLES < 1 || SETUP_CYCLES < 1 || LOG2CONFIRM < 1) begin : g_bad_param
    $error("warmboot_ctrl: LONG_PRESS_CYCLES, SETUP_CYCLES and LOG2CONFIRM must be >= 1");
  end

  state_t         state, state_nx;
  image_t         target, target_nx, image_nx;
  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  setup_cnt;
  logic           pressed, press, hold_long, active_nx;

  btn_debounce #(.LOG2DEBOUNCE(LOG2DEBOUNCE)) u_db (
    .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pressed), .press(press)
  );

  assign hold_long = (hold_cnt == HW'(LONG_PRESS_CYCLES));

`ifdef WARMBOOT_CONFIRM_EN
  logic [LOG2CONFIRM-1:0] conf_cnt;
  logic press2, conf_expired, conf_ok;
  // any press seen here necessarily follows a release of the arming press
  assign conf_expired = (conf_cnt == '1);
  assign conf_ok      = press2 && (!pressed || hold_long);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_cnt <= '0;
      press2   <= 1'b0;
    end else if (state != CONFIRM) begin
      conf_cnt <= '0;
      press2   <= 1'b0;
    end else begin
      conf_cnt <= conf_cnt + 1'b1;
      if (press) press2 <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nx  = state;
    target_nx = target;
    image_nx  = image_sel;
    case (state)
      IDLE: begin
        if (req) begin
          target_nx = req_image;
          state_nx  = ARM;
        end else if (press) begin
          state_nx = HELD;
        end
      end
      HELD: begin
        if (req) begin
          target_nx = req_image;
          state_nx  = ARM;
        end else if (hold_long) begin
          target_nx = image_sel;
`ifdef WARMBOOT_CONFIRM_EN
          state_nx  = CONFIRM;
`else
          state_nx  = ARM;
`endif
        end else if (!pressed) begin
          image_nx = image_t'((int'(image_sel) + 1) % NUM_IMAGES);
          state_nx = IDLE;
        end
      end
`ifdef WARMBOOT_CONFIRM_EN
      CONFIRM: begin
        if (req) begin
          target_nx = req_image;
          state_nx  = ARM;
        end else if (conf_ok) begin
          state_nx = ARM;
        end else if (conf_expired) begin
          state_nx = IDLE;
        end
      end
`endif
      ARM:     if (setup_cnt == SW'(SETUP_CYCLES - 1)) state_nx = BOOT;
      BOOT:    state_nx = BOOT;
      default: state_nx = IDLE;
    endcase
  end

  assign active_nx = (state_nx == ARM) || (state_nx == BOOT);

  // outputs are registered from next-state so they line up with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      image_sel <= '0;
      hold_cnt  <= '0;
      setup_cnt <= '0;
      boot      <= 1'b0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      image_sel <= image_nx;
      if (press)                       hold_cnt <= '0;
      else if (pressed && !hold_long)  hold_cnt <= hold_cnt + 1'b1;
      setup_cnt <= (state == ARM) ? setup_cnt + 1'b1 : '0;
      boot      <= (state_nx == BOOT);
      busy      <= active_nx;
      s1        <= active_nx & target_nx[1];
      s0        <= active_nx & target_nx[0];
    end
  end
endmodule

// File: tb/tb_warmboot_ctrl.sv
// Self-checking bench for warmboot_ctrl: vector table for short presses,
// directed corner sequences, randomized boot trials against a simple model.
module tb_warmboot_ctrl;
  localparam int L2DB  = 3;
  localparam int LONG  = 20;
  localparam int SETUP = 2;
  localparam int L2CF  = 6;

  logic clk = 1'b0, rst = 1'b1, btn_n = 1'b1, req = 1'b0;
  logic [1:0] req_image = 2'd0;
  logic boot, s1, s0, busy;
  logic [1:0] image_sel;

  int checks = 0, failures = 0;

  warmboot_ctrl #(
    .LOG2DEBOUNCE(L2DB), .LONG_PRESS_CYCLES(LONG),
    .SETUP_CYCLES(SETUP), .LOG2CONFIRM(L2CF)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .req(req), .req_image(req_image),
    .boot(boot), .s1(s1), .s0(s0), .image_sel(image_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         low;
    int         high;
    logic [1:0] exp_img;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    btn_n = 1'b1; req = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic press_btn(input int low, input int high);
    btn_n = 1'b0;
    repeat (low) tick();
    btn_n = 1'b1;
    repeat (high) tick();
  endtask

  task automatic chk_idle_outs(input string name);
    chk({name, ".boot"}, int'(boot), 0);
    chk({name, ".s1s0"}, int'({s1, s0}), 0);
    chk({name, ".busy"}, int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int arm_cnt, bad, t, k, mode, seen;
    logic [1:0] tgt, exp_img;

    vecs[0] = '{15, 15, 2'd1};
    vecs[1] = '{15, 15, 2'd2};
    vecs[2] = '{15, 15, 2'd3};
    vecs[3] = '{15, 15, 2'd0};
    vecs[4] = '{6,  15, 2'd0};
    vecs[5] = '{10, 15, 2'd1};
    vecs[6] = '{15, 15, 2'd2};

    // reset and idle
    do_reset();
    repeat (50) tick();
    chk_idle_outs("reset");
    chk("reset.image_sel", int'(image_sel), 0);

    // bounce: never stable long enough to register a press
    for (int i = 0; i < 40; i += 3) begin
      btn_n = ~btn_n;
      repeat (3) tick();
    end
    btn_n = 1'b1;
    repeat (20) tick();
    chk("bounce.image_sel", int'(image_sel), 0);
    chk("bounce.busy", int'(busy), 0);

    // short-press table
    for (int i = 0; i < 7; i++) begin
      press_btn(vecs[i].low, vecs[i].high);
      chk($sformatf("vec%0d.image_sel", i), int'(image_sel), int'(vecs[i].exp_img));
      chk($sformatf("vec%0d.s1s0", i), int'({s1, s0}), 0);
    end

`ifndef WARMBOOT_CONFIRM_EN
    // long press from image 2: two setup cycles then terminal boot
    arm_cnt = 0; bad = 0; seen = 0;
    btn_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy && !boot) begin
        arm_cnt++;
        if ({s1, s0} != 2'b10) bad++;
      end
      if (boot) begin
        seen = 1;
        if ({s1, s0} != 2'b10) bad++;
      end
    end
    chk("long.arm_cycles", arm_cnt, SETUP);
    chk("long.boot_seen", seen, 1);
    chk("long.select_errs", bad, 0);
    btn_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!boot || !busy || {s1, s0} != 2'b10) bad++;
    end
    chk("long.boot_held", bad, 0);
    chk("long.image_frozen", int'(image_sel), 2);
`else
    // long press then nothing: window expires, back to idle
    bad = 0;
    btn_n = 1'b0;
    repeat (40) begin tick(); if (boot) bad++; end
    btn_n = 1'b1;
    repeat (100) begin tick(); if (boot || busy) bad++; end
    chk("confirm.expire_noboot", bad, 0);
    chk("confirm.expire_image", int'(image_sel), 2);
    press_btn(15, 15);
    chk("confirm.idle_after", int'(image_sel), 3);
    // long press, release, short press inside window
    press_btn(40, 24);
    btn_n = 1'b0;
    repeat (12) tick();
    btn_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (boot) seen = 1;
    end
    chk("confirm.boot", seen, 1);
    chk("confirm.s1s0", int'({s1, s0}), 3);
`endif

    // reset asserted while in ARM clears outputs immediately
    do_reset();
    req_image = 2'd3; req = 1'b1;
    tick();
    req = 1'b0;
    chk("armrst.busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_idle_outs("armrst");
    chk("armrst.image_sel", int'(image_sel), 0);
    tick();
    rst = 1'b0;
    tick();

    // req with a press landing in the same cycle
    do_reset();
    btn_n = 1'b0;
    repeat (10) tick();
    req_image = 2'd3; req = 1'b1;
    tick();
    req = 1'b0;
    chk("req.c1.busy", int'(busy), 1);
    chk("req.c1.s1s0", int'({s1, s0}), 3);
    chk("req.c1.boot", int'(boot), 0);
    tick();
    chk("req.c2.boot", int'(boot), 0);
    tick();
    chk("req.c3.boot", int'(boot), 1);
    chk("req.c3.s1s0", int'({s1, s0}), 3);
    btn_n = 1'b1;
    repeat (30) tick();
    chk("req.image_sel", int'(image_sel), 0);

    // randomized trials against a counting model
    for (int tr = 0; tr < 10; tr++) begin
      do_reset();
      k = $urandom_range(0, 5);
      for (int p = 0; p < k; p++) press_btn($urandom_range(10, 16), $urandom_range(16, 22));
      exp_img = 2'(k % 4);
      chk($sformatf("rnd%0d.image_sel", tr), int'(image_sel), int'(exp_img));
      mode = $urandom_range(0, 1);
`ifdef WARMBOOT_CONFIRM_EN
      mode = 1;
`endif
      seen = 0; arm_cnt = 0; bad = 0;
      if (mode == 1) begin
        repeat ($urandom_range(0, 5)) tick();
        tgt = 2'($urandom_range(0, 3));
        req_image = tgt; req = 1'b1;
        tick();
        req = 1'b0;
        t = 1;
        while (!boot && t < 20) begin
          if (!busy || {s1, s0} != tgt) bad++;
          tick();
          t++;
        end
        chk($sformatf("rnd%0d.req_latency", tr), t, SETUP + 1);
      end else begin
        tgt = exp_img;
        btn_n = 1'b0;
        t = 0;
        while (!boot && t < 80) begin
          tick();
          t++;
          if (busy && !boot) begin
            arm_cnt++;
            if ({s1, s0} != tgt) bad++;
          end
        end
        btn_n = 1'b1;
        chk($sformatf("rnd%0d.arm_cycles", tr), arm_cnt, SETUP);
      end
      chk($sformatf("rnd%0d.boot", tr), int'(boot), 1);
      chk($sformatf("rnd%0d.s1s0", tr), int'({s1, s0}), int'(tgt));
      chk($sformatf("rnd%0d.arm_errs", tr), bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
